// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : pipeline sequencing controller (load-use, flush, fetch wait,
//               MUL/DIV freeze) with saturating stall/flush counters
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             id_is_muldiv,
  input  logic             muldiv_is_div,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             flush,
  output logic             id_ex_bubble,
  output logic             muldiv_start,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MD_BUSY   = 2'd1,
    MD_RETIRE = 2'd2
  } state_t;

  // The start cycle and the retire transition each take one busy cycle.
  localparam logic [5:0] MUL_INIT = 6'(MUL_LAT - 2);
  localparam logic [5:0] DIV_INIT = 6'(DIV_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [5:0] md_cnt;
  logic       lu;

  assign lu = ex_mem_read && (ex_rt != 5'd0) &&
              ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));

  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    flush        = 1'b0;
    id_ex_bubble = 1'b0;
    muldiv_start = 1'b0;
    muldiv_busy  = 1'b0;
    case (state)
      RUN: begin
        if (lu) begin
          pc_write     = 1'b0;
          IF_ID_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end else if (id_is_muldiv) begin
          pc_write     = 1'b0;
          IF_ID_write  = 1'b0;
          id_ex_bubble = 1'b1;
          muldiv_start = 1'b1;
          muldiv_busy  = 1'b1;
        end else if (branch_taken || jump) begin
          flush = 1'b1;
        end else if (!imem_ready) begin
          pc_write = 1'b0;
          flush    = 1'b1;
        end
      end
      MD_BUSY: begin
        pc_write     = 1'b0;
        IF_ID_write  = 1'b0;
        id_ex_bubble = 1'b1;
        muldiv_busy  = 1'b1;
      end
      MD_RETIRE: begin
        // Fetch wait still applies while the MUL/DIV moves into EX.
        if (!imem_ready) begin
          pc_write = 1'b0;
          flush    = 1'b1;
        end
      end
      default: begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      md_cnt    <= 6'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!lu && id_is_muldiv) begin
            state  <= MD_BUSY;
            md_cnt <= muldiv_is_div ? DIV_INIT : MUL_INIT;
          end
        end
        MD_BUSY: begin
          if (md_cnt != 6'd0) md_cnt <= md_cnt - 6'd1;
          else                state  <= MD_RETIRE;
        end
        MD_RETIRE: state <= RUN;
        default:   state <= RUN;
      endcase
      if (!pc_write && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush && (flush_cnt != {CNT_W{1'b1}}))     flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expected outputs per cycle,
// an independent monitor pops and compares them mid-cycle.
`default_nettype none

module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rs, id_uses_rt, ex_mem_read, branch_taken, jump;
  logic id_is_muldiv, muldiv_is_div, imem_ready;
  logic pc_write, IF_ID_write, flush, id_ex_bubble, muldiv_start, muldiv_busy;
  logic [15:0] stall_cnt, flush_cnt;
  logic s_pc_write, s_IF_ID_write, s_flush, s_id_ex_bubble, s_muldiv_start, s_muldiv_busy;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       nm;
    logic [5:0]  outs;   // pc_write, IF_ID_write, flush, bubble, start, busy
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  exp_t sb[$];
  int   exp_stall = 0;
  int   exp_flush = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .jump(jump), .id_is_muldiv(id_is_muldiv),
    .muldiv_is_div(muldiv_is_div), .imem_ready(imem_ready), .pc_write(pc_write),
    .IF_ID_write(IF_ID_write), .flush(flush), .id_ex_bubble(id_ex_bubble),
    .muldiv_start(muldiv_start), .muldiv_busy(muldiv_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .jump(jump), .id_is_muldiv(id_is_muldiv),
    .muldiv_is_div(muldiv_is_div), .imem_ready(imem_ready), .pc_write(s_pc_write),
    .IF_ID_write(s_IF_ID_write), .flush(s_flush), .id_ex_bubble(s_id_ex_bubble),
    .muldiv_start(s_muldiv_start), .muldiv_busy(s_muldiv_busy),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Push one cycle's expected outputs; counters reflect all earlier cycles.
  task automatic expect_cyc(input string nm, input logic [5:0] outs);
    exp_t e;
    e.nm   = nm;
    e.outs = outs;
    e.scnt = 16'(exp_stall);
    e.fcnt = 16'(exp_flush);
    sb.push_back(e);
    if (!rst) begin
      if (!outs[5]) exp_stall++;
      if (outs[3])  exp_flush++;
    end
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; id_is_muldiv = 1'b0;
    muldiv_is_div = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic set_lu(input logic on);
    ex_mem_read = on; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = on;
  endtask

  localparam logic [5:0] O_RUN   = 6'b110000;
  localparam logic [5:0] O_STALL = 6'b000100;
  localparam logic [5:0] O_FLUSH = 6'b111000;
  localparam logic [5:0] O_WAIT  = 6'b011000;
  localparam logic [5:0] O_START = 6'b000111;
  localparam logic [5:0] O_BUSY  = 6'b000101;

  // Monitor: compares each scoreboard entry mid-cycle, away from the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.nm, ".outs"}, {26'd0, pc_write, IF_ID_write, flush, id_ex_bubble,
                              muldiv_start, muldiv_busy}, {26'd0, e.outs});
        chk({e.nm, ".stall_cnt"}, {16'd0, stall_cnt}, {16'd0, e.scnt});
        chk({e.nm, ".flush_cnt"}, {16'd0, flush_cnt}, {16'd0, e.fcnt});
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk); expect_cyc("reset", O_RUN);
    @(negedge clk); rst = 1'b0; expect_cyc("idle", O_RUN);

    // load-use on rs, then ex_rt=0 must not stall
    @(negedge clk); set_lu(1'b1); expect_cyc("lu_rs", O_STALL);
    @(negedge clk); ex_rt = 5'd0; expect_cyc("lu_r0", O_RUN);
    // load-use on rt, and a match on an unused rt
    @(negedge clk); idle_inputs(); ex_mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5;
    id_uses_rt = 1'b1; expect_cyc("lu_rt", O_STALL);
    @(negedge clk); id_uses_rt = 1'b0; expect_cyc("lu_rt_unused", O_RUN);

    // branch masked by load-use, then taken once the hazard clears
    @(negedge clk); idle_inputs(); set_lu(1'b1); branch_taken = 1'b1;
    expect_cyc("lu_branch", O_STALL);
    @(negedge clk); set_lu(1'b0); expect_cyc("branch", O_FLUSH);
    @(negedge clk); idle_inputs(); expect_cyc("after_branch", O_RUN);

    // multiply: 4 busy cycles, retire ignores id_is_muldiv and jump
    @(negedge clk); id_is_muldiv = 1'b1; expect_cyc("mul_start", O_START);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); jump = i[0]; expect_cyc("mul_busy", O_BUSY);
    end
    @(negedge clk); jump = 1'b0; expect_cyc("mul_retire", O_RUN);
    @(negedge clk); idle_inputs(); expect_cyc("after_mul", O_RUN);

    // divide started alongside a branch; hazards toggled through the freeze
    @(negedge clk); id_is_muldiv = 1'b1; muldiv_is_div = 1'b1; branch_taken = 1'b1;
    expect_cyc("div_start", O_START);
    for (int i = 0; i < 31; i++) begin
      @(negedge clk); branch_taken = i[0]; imem_ready = i[1]; set_lu(i[2]);
      expect_cyc("div_busy", O_BUSY);
    end
    @(negedge clk); branch_taken = 1'b1; imem_ready = 1'b0; set_lu(1'b1);
    expect_cyc("div_retire_wait", O_WAIT);
    @(negedge clk); idle_inputs(); expect_cyc("after_div", O_RUN);

    // fetch wait, overridden by jump
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); imem_ready = 1'b0; expect_cyc("imem_wait", O_WAIT);
    end
    @(negedge clk); jump = 1'b1; expect_cyc("imem_jump", O_FLUSH);

    // load-use beats a multiply; multiply starts the following cycle
    @(negedge clk); idle_inputs(); id_is_muldiv = 1'b1; set_lu(1'b1);
    expect_cyc("lu_mul", O_STALL);
    @(negedge clk); set_lu(1'b0); expect_cyc("mul2_start", O_START);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); expect_cyc("mul2_busy", O_BUSY);
    end
    @(negedge clk); idle_inputs(); expect_cyc("mul2_retire", O_RUN);

    // asynchronous reset mid-divide
    @(negedge clk); id_is_muldiv = 1'b1; muldiv_is_div = 1'b1;
    expect_cyc("div2_start", O_START);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); idle_inputs(); expect_cyc("div2_busy", O_BUSY);
    end
    @(negedge clk); rst = 1'b1; exp_stall = 0; exp_flush = 0;
    expect_cyc("rst_mid_div", O_RUN);
    @(negedge clk); rst = 1'b0; expect_cyc("post_rst", O_RUN);

    // 20 stalls: wide counter reaches 20, 4-bit counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); set_lu(1'b1); expect_cyc("sat_stall", O_STALL);
    end
    @(negedge clk); idle_inputs(); expect_cyc("sat_done", O_RUN);
    #3;
    chk("small_stall_sat", {28'd0, s_stall_cnt}, 32'd15);
    chk("small_flush_zero", {28'd0, s_flush_cnt}, 32'd0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #4;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
